// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: HPM counters with multi-bit lane increments, privilege inhibit and sticky overflow IRQ
module hpm_counter_bank #(
  parameter int NumCounters   = 29,
  parameter int CounterWidth  = 64,
  parameter int NumEvents     = 64,
  parameter int EventSelWidth = 6,
  parameter int IncWidth      = 2,
  parameter int XLEN          = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          debug_mode_i,
  input  logic [1:0]                    priv_lvl_i,
  input  logic [11:0]                   csr_addr_i,
  input  logic                          csr_we_i,
  input  logic [XLEN-1:0]               csr_wdata_i,
  output logic [XLEN-1:0]               csr_rdata_o,
  output logic                          csr_hit_o,
  output logic                          csr_illegal_o,
  input  logic [NumEvents*IncWidth-1:0] event_inc_i,
  input  logic [31:0]                   mcountinhibit_i,
  output logic                          ovf_irq_o
);
  logic [4:0] n, idx;
  logic lo_ok, win_mc, win_mch, win_ev, win_c, win_ch, is_h, impl, wr_ok;
  logic [63:0] wd64, cnt64, cnt_sh, cnt_wval;
  logic [XLEN-1:0] ev_rd;
  logic [CounterWidth-1:0] cnt_q [NumCounters];
  logic [EventSelWidth-1:0] sel_q [NumCounters];
  logic [NumCounters-1:0] of_q, minh_q, sinh_q, uinh_q;
  // Every window keeps counter n at offset n from a 32-aligned base, so n is the low address bits
  assign n        = csr_addr_i[4:0];
  assign idx      = n - 5'd3;
  assign lo_ok    = n >= 5'd3;
  assign win_mc   = csr_addr_i[11:5] == 7'h58 && lo_ok;
  assign win_mch  = csr_addr_i[11:5] == 7'h5C && lo_ok;
  assign win_ev   = csr_addr_i[11:5] == 7'h19 && lo_ok;
  assign win_c    = csr_addr_i[11:5] == 7'h60 && lo_ok;
  assign win_ch   = csr_addr_i[11:5] == 7'h64 && lo_ok;
  assign is_h     = win_mch || win_ch;
  assign csr_hit_o = win_mc || win_mch || win_ev || win_c || win_ch;
  assign impl     = int'(idx) < NumCounters;
  assign csr_illegal_o = (csr_we_i && (win_c || win_ch)) || (is_h && XLEN == 64);
  assign wr_ok    = csr_we_i && !csr_illegal_o && impl;
  assign wd64     = 64'(csr_wdata_i);
  always_comb begin
    cnt64 = '0;
    ev_rd = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (idx == 5'(i)) begin
        cnt64 = 64'(cnt_q[i]);
        ev_rd[XLEN-1] = of_q[i];
        ev_rd[XLEN-2] = minh_q[i];
        ev_rd[XLEN-3] = sinh_q[i];
        ev_rd[XLEN-4] = uinh_q[i];
        ev_rd[EventSelWidth-1:0] = sel_q[i];
      end
    end
  end
  assign cnt_sh   = is_h ? {32'b0, cnt64[63:32]} : cnt64;
  assign cnt_wval = win_mch ? {wd64[31:0], cnt64[31:0]} :
                    XLEN == 32 ? {cnt64[63:32], wd64[31:0]} : wd64;
  assign csr_rdata_o = (csr_illegal_o || !impl) ? '0 :
                       win_ev ? ev_rd :
                       (win_mc || win_mch || win_c || win_ch) ? XLEN'(cnt_sh) : '0;
  for (genvar k = 0; k < NumCounters; k++) begin : g_cnt
    logic [CounterWidth-1:0] cnt_r;
    logic [EventSelWidth-1:0] sel_r;
    logic of_r, minh_r, sinh_r, uinh_r, hit, wr_c, wr_e, inh, wrap;
    logic [IncWidth-1:0] inc;
    logic [CounterWidth:0] sum;
    assign hit  = wr_ok && idx == 5'(k);
    assign wr_c = hit && (win_mc || win_mch);
    assign wr_e = hit && win_ev;
    assign inh  = debug_mode_i || mcountinhibit_i[k+3] || (priv_lvl_i == 2'd3 && minh_r) ||
                  (priv_lvl_i == 2'd1 && sinh_r) || (priv_lvl_i == 2'd0 && uinh_r);
    assign inc  = (inh || sel_r == '0 || int'(sel_r) >= NumEvents) ? '0 :
                  event_inc_i[int'(sel_r)*IncWidth +: IncWidth];
    assign sum  = {1'b0, cnt_r} + (CounterWidth+1)'(inc);
    assign wrap = sum[CounterWidth] && !wr_c;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_r  <= '0;
        sel_r  <= '0;
        of_r   <= 1'b0;
        minh_r <= 1'b0;
        sinh_r <= 1'b0;
        uinh_r <= 1'b0;
      end else begin
        cnt_r <= wr_c ? CounterWidth'(cnt_wval) : sum[CounterWidth-1:0];
        of_r  <= (wr_e ? csr_wdata_i[XLEN-1] : of_r) | wrap;
        if (wr_e) begin
          minh_r <= csr_wdata_i[XLEN-2];
          sinh_r <= csr_wdata_i[XLEN-3];
          uinh_r <= csr_wdata_i[XLEN-4];
          sel_r  <= csr_wdata_i[EventSelWidth-1:0];
        end
      end
    end
    assign cnt_q[k]  = cnt_r;
    assign sel_q[k]  = sel_r;
    assign of_q[k]   = of_r;
    assign minh_q[k] = minh_r;
    assign sinh_q[k] = sinh_r;
    assign uinh_q[k] = uinh_r;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_irq_o <= 1'b0;
    else ovf_irq_o <= |of_q;
  end
endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb_hpm_counter_bank: directed vector table plus hand sequences for counting, overflow and 32-bit access
module tb_hpm_counter_bank;
  logic clk = 0, rst_ni = 0, debug = 0, we = 0, hit, ill, irq;
  logic we32 = 0, hit32, ill32, irq32;
  logic [1:0] priv = 2'd3;
  logic [11:0] addr = '0, a32 = '0;
  logic [63:0] wdata = '0, rdata;
  logic [31:0] wd32 = '0, rd32, mcinh = '0;
  logic [127:0] ev_inc = '0;
  int n_vec = 0, n_bad = 0;
  always #50 clk = ~clk;
  hpm_counter_bank u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .debug_mode_i(debug), .priv_lvl_i(priv),
    .csr_addr_i(addr), .csr_we_i(we), .csr_wdata_i(wdata), .csr_rdata_o(rdata),
    .csr_hit_o(hit), .csr_illegal_o(ill), .event_inc_i(ev_inc),
    .mcountinhibit_i(mcinh), .ovf_irq_o(irq));
  hpm_counter_bank #(.NumCounters(4), .XLEN(32)) u_d32 (
    .clk_i(clk), .rst_ni(rst_ni), .debug_mode_i(debug), .priv_lvl_i(priv),
    .csr_addr_i(a32), .csr_we_i(we32), .csr_wdata_i(wd32), .csr_rdata_o(rd32),
    .csr_hit_o(hit32), .csr_illegal_o(ill32), .event_inc_i(ev_inc),
    .mcountinhibit_i(mcinh), .ovf_irq_o(irq32));
  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic        chk_rd;
    logic [63:0] exp_rd;
    logic        exp_hit;
    logic        exp_ill;
  } vec_t;
  vec_t tbl [20];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    addr = a; we = 1; wdata = d;
    tick;
    we = 0;
  endtask
  task automatic rd(input string nm, input logic [11:0] a, input logic [63:0] e);
    addr = a;
    #1;
    chk(nm, rdata, e);
  endtask
  task automatic wr32(input logic [11:0] a, input logic [31:0] d);
    a32 = a; we32 = 1; wd32 = d;
    tick;
    we32 = 0;
  endtask
  task automatic rd32c(input string nm, input logic [11:0] a, input logic [31:0] e);
    a32 = a;
    #1;
    chk(nm, 64'(rd32), 64'(e));
  endtask
  task automatic lane(input int e, input int v);
    ev_inc[e*2 +: 2] = 2'(v);
  endtask
  initial begin
    tbl[0]  = '{12'hB03, 1'b0, 64'h0,    1'b1, 64'h0,    1'b1, 1'b0};
    tbl[1]  = '{12'hB03, 1'b1, 64'h1234, 1'b1, 64'h0,    1'b1, 1'b0};
    tbl[2]  = '{12'hB03, 1'b0, 64'h0,    1'b1, 64'h1234, 1'b1, 1'b0};
    tbl[3]  = '{12'hC03, 1'b0, 64'h0,    1'b1, 64'h1234, 1'b1, 1'b0};
    tbl[4]  = '{12'hB05, 1'b1, 64'h9,    1'b0, 64'h0,    1'b1, 1'b0};
    tbl[5]  = '{12'hB05, 1'b0, 64'h0,    1'b1, 64'h9,    1'b1, 1'b0};
    tbl[6]  = '{12'hB1F, 1'b1, 64'h7,    1'b0, 64'h0,    1'b1, 1'b0};
    tbl[7]  = '{12'hC1F, 1'b0, 64'h0,    1'b1, 64'h7,    1'b1, 1'b0};
    tbl[8]  = '{12'h324, 1'b1, '1,       1'b0, 64'h0,    1'b1, 1'b0};
    tbl[9]  = '{12'h324, 1'b0, 64'h0,    1'b1, 64'hF000_0000_0000_003F, 1'b1, 1'b0};
    tbl[10] = '{12'h324, 1'b1, 64'h0,    1'b0, 64'h0,    1'b1, 1'b0};
    tbl[11] = '{12'h324, 1'b0, 64'h0,    1'b1, 64'h0,    1'b1, 1'b0};
    tbl[12] = '{12'hB83, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b1};
    tbl[13] = '{12'hC03, 1'b1, 64'h5,    1'b0, 64'h0,    1'b1, 1'b1};
    tbl[14] = '{12'hB03, 1'b0, 64'h0,    1'b1, 64'h1234, 1'b1, 1'b0};
    tbl[15] = '{12'h300, 1'b0, 64'h0,    1'b1, 64'h0,    1'b0, 1'b0};
    tbl[16] = '{12'hB20, 1'b0, 64'h0,    1'b1, 64'h0,    1'b0, 1'b0};
    tbl[17] = '{12'hB02, 1'b0, 64'h0,    1'b1, 64'h0,    1'b0, 1'b0};
    tbl[18] = '{12'h33F, 1'b0, 64'h0,    1'b1, 64'h0,    1'b1, 1'b0};
    tbl[19] = '{12'hC83, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b1};
    repeat (2) tick;
    rst_ni = 1;
    tick;
    chk("reset_irq", 64'(irq), 64'h0);
    rd("reset_ev3", 12'h323, 64'h0);
    for (int i = 0; i < 20; i++) begin
      addr = tbl[i].addr; we = tbl[i].we; wdata = tbl[i].wdata;
      #1;
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_hit", i), 64'(hit), 64'(tbl[i].exp_hit));
      chk($sformatf("tbl%0d_illegal", i), 64'(ill), 64'(tbl[i].exp_ill));
      tick;
      we = 0;
    end
    tick;
    // T1: lane 5 adds 2 for ten cycles
    wr(12'hB03, 64'h0);
    wr(12'h323, 64'h5);
    lane(5, 2);
    repeat (10) tick;
    lane(5, 0);
    rd("t1_b03", 12'hB03, 64'd20);
    rd("t1_c03", 12'hC03, 64'd20);
    // T2: wrap sets OF, irq follows one cycle later and clears one cycle after OF is written 0
    chk("t2_irq_pre", 64'(irq), 64'h0);
    wr(12'hB03, '1);
    lane(5, 1);
    tick;
    lane(5, 0);
    rd("t2_wrap_cnt", 12'hB03, 64'h0);
    rd("t2_of", 12'h323, 64'h8000_0000_0000_0005);
    chk("t2_irq_lag", 64'(irq), 64'h0);
    tick;
    chk("t2_irq_set", 64'(irq), 64'h1);
    wr(12'h323, 64'h5);
    chk("t2_irq_hold", 64'(irq), 64'h1);
    tick;
    chk("t2_irq_clr", 64'(irq), 64'h0);
    // T3: mcountinhibit, debug, UINH and MINH
    mcinh = 32'h8;
    lane(5, 2);
    repeat (3) tick;
    rd("t3_mcinh", 12'hB03, 64'h0);
    mcinh = 0; debug = 1;
    repeat (3) tick;
    rd("t3_debug", 12'hB03, 64'h0);
    debug = 0;
    lane(5, 0);
    wr(12'h323, 64'h1000_0000_0000_0005);
    priv = 2'd0;
    lane(5, 2);
    repeat (3) tick;
    rd("t3_uinh_u", 12'hB03, 64'h0);
    priv = 2'd3;
    repeat (2) tick;
    rd("t3_uinh_m", 12'hB03, 64'd4);
    lane(5, 0);
    wr(12'h323, 64'h4000_0000_0000_0005);
    lane(5, 2);
    tick;
    rd("t3_minh_m", 12'hB03, 64'd4);
    priv = 2'd1;
    tick;
    rd("t3_minh_s", 12'hB03, 64'd6);
    lane(5, 0);
    priv = 2'd3;
    // T4: write beats a same-cycle increment
    wr(12'h324, 64'h7);
    lane(7, 3);
    wr(12'hB04, 64'd100);
    rd("t4_write_wins", 12'hB04, 64'd100);
    tick;
    rd("t4_next", 12'hB04, 64'd103);
    lane(7, 0);
    // event write during a wrap still leaves OF set
    wr(12'h325, 64'h9);
    wr(12'hB05, '1);
    lane(9, 1);
    wr(12'h325, 64'h9);
    lane(9, 0);
    rd("ev_wr_wrap_of", 12'h325, 64'h8000_0000_0000_0009);
    rd("ev_wr_wrap_cnt", 12'hB05, 64'h0);
    wr(12'h325, 64'h0);
    // select 0 never counts even with lane 0 active
    lane(0, 3);
    tick;
    lane(0, 0);
    rd("sel0_nocount", 12'hB06, 64'h0);
    // T5/T6: 32-bit instance with four counters
    wr32(12'hB83, 32'h1);
    rd32c("t5_lo", 12'hB03, 32'h0);
    rd32c("t5_hi", 12'hB83, 32'h1);
    chk("t5_hi_legal", 64'(ill32), 64'h0);
    rd32c("t5_hi_ro", 12'hC83, 32'h1);
    wr32(12'hB03, 32'hFFFF_FFFF);
    rd32c("t5_lo_keep_hi", 12'hB83, 32'h1);
    wr32(12'h323, 32'h1);
    lane(1, 1);
    tick;
    lane(1, 0);
    rd32c("t5_carry_lo", 12'hB03, 32'h0);
    rd32c("t5_carry_hi", 12'hB83, 32'h2);
    a32 = 12'hB1F;
    #1;
    chk("t6_unimpl_hit", 64'(hit32), 64'h1);
    chk("t6_unimpl_rd", 64'(rd32), 64'h0);
    wr32(12'hB1F, 32'h5);
    rd32c("t6_unimpl_wr", 12'hB1F, 32'h0);
    // asynchronous reset mid-count
    wr(12'h323, 64'h5);
    wr(12'hB03, '1);
    lane(5, 2);
    tick;
    #10;
    rst_ni = 0;
    #1;
    rd("areset_cnt", 12'hB03, 64'h0);
    rd("areset_ev", 12'h323, 64'h0);
    chk("areset_irq", 64'(irq), 64'h0);
    lane(5, 0);
    tick;
    rst_ni = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
